// File: rtl/pdl_puf_array_ctrl.sv
// Controller for a bank of PDL PUF cells sharing one challenge and trigger.
// Runs NUM_EVAL reset/fire/settle/sample rounds and majority-votes each response bit.
module pdl_puf_array_ctrl #(
    parameter int unsigned NUM_PUF       = 6,
    parameter int unsigned CHAL_W        = 128,
    parameter int unsigned NUM_EVAL      = 5,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [CHAL_W-1:0]  challenge,
    output logic               busy,
    output logic               done,
    output logic [NUM_PUF-1:0] response,
    output logic [NUM_PUF-1:0] unstable,
    output logic [CHAL_W-1:0]  puf_challenge,
    output logic               puf_trigger,
    output logic               puf_reset,
    input  logic [NUM_PUF-1:0] puf_resp
);

    localparam int unsigned OW   = $clog2(NUM_EVAL + 1);
    localparam int unsigned MAXC = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FIRE,
        SAMPLE,
        DONE
    } state_t;

    state_t                       state, state_d;
    logic [CW-1:0]                cnt, cnt_d;
    logic [OW-1:0]                eval, eval_d;
    logic [NUM_PUF-1:0][OW-1:0]   ones, ones_d;
    logic [NUM_PUF-1:0]           sync1, sync2;
    logic [CHAL_W-1:0]            chal_d;
    logic [NUM_PUF-1:0]           resp_d, unst_d;
    logic                         busy_d, done_d, trig_d, prst_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            eval          <= '0;
            ones          <= '0;
            sync1         <= '0;
            sync2         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            response      <= '0;
            unstable      <= '0;
            puf_challenge <= '0;
            puf_trigger   <= 1'b0;
            puf_reset     <= 1'b1;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            eval          <= eval_d;
            ones          <= ones_d;
            sync1         <= puf_resp;
            sync2         <= sync1;
            busy          <= busy_d;
            done          <= done_d;
            response      <= resp_d;
            unstable      <= unst_d;
            puf_challenge <= chal_d;
            puf_trigger   <= trig_d;
            puf_reset     <= prst_d;
        end
    end

    // Next state; outputs are decoded from the next state so they line up with it
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        eval_d  = eval;
        ones_d  = ones;
        chal_d  = puf_challenge;
        resp_d  = response;
        unst_d  = unstable;

        case (state)
            IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    ones_d  = '0;
                    eval_d  = '0;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = FIRE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            FIRE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            SAMPLE: begin
                for (int i = 0; i < int'(NUM_PUF); i++) begin
                    ones_d[i] = ones[i] + OW'(sync2[i]);
                end
                eval_d  = eval + OW'(1);
                state_d = (eval_d == OW'(NUM_EVAL)) ? DONE : CLEAR;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == DONE) begin
            for (int i = 0; i < int'(NUM_PUF); i++) begin
                resp_d[i] = (ones_d[i] > OW'(NUM_EVAL / 2));
                unst_d[i] = (ones_d[i] != '0) && (ones_d[i] != OW'(NUM_EVAL));
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        trig_d = (state_d == FIRE) || (state_d == SAMPLE);
        prst_d = !trig_d;
    end

endmodule

// File: tb/tb_pdl_puf_array_ctrl.sv
// Directed bench for pdl_puf_array_ctrl: default instance with a trigger-driven
// cell model, plus a small-parameter instance with a constant cell response.
`timescale 1ns/1ps
module tb_pdl_puf_array_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic         start;
    logic [127:0] challenge;
    logic         busy, done, puf_trigger, puf_reset;
    logic [5:0]   response, unstable, puf_resp;
    logic [127:0] puf_challenge;

    // Small instance: NUM_PUF=16, NUM_EVAL=3, RST_CYCLES=1, SETTLE_CYCLES=3
    logic         start_s;
    logic [31:0]  challenge_s;
    logic         busy_s, done_s, puf_trigger_s, puf_reset_s;
    logic [15:0]  response_s, unstable_s, puf_resp_s;
    logic [31:0]  puf_challenge_s;

    pdl_puf_array_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .challenge(challenge),
        .busy(busy), .done(done), .response(response), .unstable(unstable),
        .puf_challenge(puf_challenge), .puf_trigger(puf_trigger),
        .puf_reset(puf_reset), .puf_resp(puf_resp)
    );

    pdl_puf_array_ctrl #(
        .NUM_PUF(16), .CHAL_W(32), .NUM_EVAL(3), .RST_CYCLES(1), .SETTLE_CYCLES(3)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start_s), .challenge(challenge_s),
        .busy(busy_s), .done(done_s), .response(response_s), .unstable(unstable_s),
        .puf_challenge(puf_challenge_s), .puf_trigger(puf_trigger_s),
        .puf_reset(puf_reset_s), .puf_resp(puf_resp_s)
    );

    // Cell model: each trigger rise starts a new evaluation with its own response word
    int         trig_cnt = 0;
    int         trig_base;
    logic [5:0] resp_tbl [8];
    logic [2:0] tbl_idx;
    always @(posedge puf_trigger) trig_cnt <= trig_cnt + 1;
    assign tbl_idx  = 3'(trig_cnt - trig_base);
    assign puf_resp = resp_tbl[tbl_idx];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_tbl(input logic [5:0] v0, v1, v2, v3, v4);
        resp_tbl[0] = 6'h00;
        resp_tbl[1] = v0; resp_tbl[2] = v1; resp_tbl[3] = v2;
        resp_tbl[4] = v3; resp_tbl[5] = v4;
        resp_tbl[6] = 6'h00; resp_tbl[7] = 6'h00;
    endtask

    // Starts one evaluation, observes a fixed window; pulses ignored starts at ign_a/ign_b
    task automatic run_eval(input logic [127:0] chal, input int ign_a, input int ign_b,
                            output int lat, output int ndone, output int ntrig);
        trig_base = trig_cnt;
        challenge = chal;
        start     = 1'b1;
        lat = 0; ndone = 0; ntrig = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 120; n++) begin
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
            end
            if (puf_trigger) ntrig++;
            if (n == ign_a || n == ign_b) begin
                start     = 1'b1;
                challenge = ~chal;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    localparam logic [127:0] CHAL1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] CHAL2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    initial begin
        int lat, nd, nt;
        reset_n     = 1'b0;
        start       = 1'b0;
        start_s     = 1'b0;
        challenge   = '0;
        challenge_s = '0;
        puf_resp_s  = 16'hA5C3;
        trig_base   = 0;
        set_tbl(6'h00, 6'h00, 6'h00, 6'h00, 6'h00);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_puf_reset", 128'(puf_reset), 128'd1);
        check("rst_trigger", 128'(puf_trigger), 128'd0);
        check("rst_response", 128'(response), 128'd0);
        check("rst_unstable", 128'(unstable), 128'd0);
        check("rst_challenge", puf_challenge, 128'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_puf_reset", 128'(puf_reset), 128'd1);

        // Constant response on every evaluation
        set_tbl(6'b101100, 6'b101100, 6'b101100, 6'b101100, 6'b101100);
        run_eval(CHAL1, 0, 0, lat, nd, nt);
        check("t1_latency", 128'(lat), 128'd106);
        check("t1_done_count", 128'(nd), 128'd1);
        check("t1_trigger_cycles", 128'(nt), 128'd85);
        check("t1_response", 128'(response), 128'(6'b101100));
        check("t1_unstable", 128'(unstable), 128'd0);
        check("t1_challenge", puf_challenge, CHAL1);
        check("t1_busy_after", 128'(busy), 128'd0);

        // Bit 0 votes 1,1,0,1,0 -> majority 1 and flagged unstable
        set_tbl(6'b000001, 6'b000001, 6'b000000, 6'b000001, 6'b000000);
        run_eval(CHAL2, 0, 0, lat, nd, nt);
        check("t2_latency", 128'(lat), 128'd106);
        check("t2_response", 128'(response), 128'(6'b000001));
        check("t2_unstable", 128'(unstable), 128'(6'b000001));

        // Starts during busy are ignored
        set_tbl(6'b010011, 6'b010011, 6'b010011, 6'b010011, 6'b010011);
        run_eval(CHAL1, 10, 50, lat, nd, nt);
        check("t3_latency", 128'(lat), 128'd106);
        check("t3_done_count", 128'(nd), 128'd1);
        check("t3_challenge", puf_challenge, CHAL1);
        check("t3_response", 128'(response), 128'(6'b010011));

        // Asynchronous reset mid-evaluation
        trig_base = trig_cnt;
        challenge = CHAL2;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("t4_busy_before", 128'(busy), 128'd1);
        reset_n = 1'b0;
        #1;
        check("t4_busy", 128'(busy), 128'd0);
        check("t4_done", 128'(done), 128'd0);
        check("t4_puf_reset", 128'(puf_reset), 128'd1);
        check("t4_trigger", 128'(puf_trigger), 128'd0);
        check("t4_response", 128'(response), 128'd0);
        check("t4_challenge", puf_challenge, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        set_tbl(6'b110101, 6'b110101, 6'b110101, 6'b110101, 6'b110101);
        run_eval(CHAL2, 0, 0, lat, nd, nt);
        check("t4_latency", 128'(lat), 128'd106);
        check("t4_done_count", 128'(nd), 128'd1);
        check("t4_response_after", 128'(response), 128'(6'b110101));

        // Small-parameter instance
        lat = 0; nd = 0;
        challenge_s = 32'h1357_9BDF;
        start_s     = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (done_s) begin
                nd++;
                if (lat == 0) lat = n;
            end
            @(posedge clk); #1;
        end
        check("s_latency", 128'(lat), 128'd16);
        check("s_done_count", 128'(nd), 128'd1);
        check("s_response", 128'(response_s), 128'h0000_A5C3);
        check("s_unstable", 128'(unstable_s), 128'd0);
        check("s_challenge", 128'(puf_challenge_s), 128'h1357_9BDF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
